// File: rtl/distance_occupancy_filter.sv
// -----------------------------------------------------------------------------
// distance_occupancy_filter
//
// Purpose:
//   Conditions raw ultrasonic distance readings for the register interface.
//   Each rising edge of sample_valid delivers one reading. In-range readings
//   are averaged over a 4-entry moving window. A hysteresis/confirm FSM turns
//   the averaged distance into a car-present decision. A watchdog plus a
//   consecutive-bad-sample counter flag a broken sensor.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   sample_data   in  16   raw distance from the sensor FSM
//   sample_valid  in   1   data-valid; its rising edge marks a new sample
//   filt_data     out 16   average of the last 4 in-range readings (truncated)
//   filt_valid    out  1   one-cycle pulse when filt_data updates
//   car_present   out  1   occupancy decision
//   broken        out  1   sensor fault flag
//   status        out 16   {12'b0, window_full, broken, car_present,
//                           filt_valid_sticky}
//
// Timing: a sample accepted on edge E updates the running sum on E+1 and
// drives filt_data/filt_valid on E+2. car_present follows one cycle after
// the filt_valid pulse that decided it.
// -----------------------------------------------------------------------------
module distance_occupancy_filter #(
  parameter logic [15:0] MAX_RANGE      = 16'd4000,
  parameter logic [15:0] CAR_NEAR       = 16'd300,
  parameter logic [15:0] CAR_FAR        = 16'd400,
  parameter int          CONFIRM_N      = 4,
  parameter int          TIMEOUT_CYCLES = 5_000_000,
  parameter int          BAD_LIMIT      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic [15:0] filt_data,
  output logic        filt_valid,
  output logic        car_present,
  output logic        broken,
  output logic [15:0] status
);

  localparam int              DATA_W = 16;
  localparam int              SUM_W  = DATA_W + 2;
  localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]      BAD_MAX = 8'(BAD_LIMIT);
  localparam logic [3:0]      CONF    = 4'(CONFIRM_N);
  localparam logic [2:0]      FILL_FULL = 3'd4;

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_ARRIVING = 2'd1;
  localparam logic [1:0] S_OCCUPIED = 2'd2;
  localparam logic [1:0] S_LEAVING  = 2'd3;

  function automatic logic [WD_W-1:0] sat_inc_wd(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + WD_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_bad(input logic [7:0] v);
    return (v == BAD_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic [DATA_W-1:0] trunc_avg4(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:2];
  endfunction

  // Control / health state
  logic              r_sv_prev;
  logic [WD_W-1:0]   r_wd;
  logic [7:0]        r_bad;
  logic              r_broken;

  // Stage p0: accepted sample
  logic [DATA_W-1:0] r_data_p0;
  logic              r_vld_p0;

  // Stage p1: window and running sum
  logic [DATA_W-1:0] r_win_p1 [4];
  logic [SUM_W-1:0]  r_sum_p1;
  logic [2:0]        r_fill_p1;
  logic              r_vld_p1;

  // Stage p2: filter outputs
  logic [DATA_W-1:0] r_filt_data_p2;
  logic              r_vld_p2;
  logic              r_sticky;

  // Occupancy FSM
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_car;

  logic              w_accept;
  logic              w_in_range;
  logic              w_acc_good;
  logic              w_acc_bad;
  logic [WD_W-1:0]   w_wd_next;
  logic [7:0]        w_bad_next;
  logic              w_broken_next;
  logic [SUM_W-1:0]  w_sum_next;
  logic              w_near;
  logic              w_far;
  logic [1:0]        w_state_next;
  logic [3:0]        w_cnt_next;
  logic [3:0]        w_cnt_inc;

  assign w_accept   = sample_valid & ~r_sv_prev;
  assign w_in_range = (sample_data != '0) && (sample_data <= MAX_RANGE);
  assign w_acc_good = w_accept & w_in_range;
  assign w_acc_bad  = w_accept & ~w_in_range;

  // An in-range accept clears the fault path outright, so it wins against a
  // watchdog expiring on the same edge.
  assign w_wd_next  = w_acc_good ? '0 : sat_inc_wd(r_wd);
  assign w_bad_next = w_acc_good ? '0 : (w_acc_bad ? sat_inc_bad(r_bad) : r_bad);
  assign w_broken_next = w_acc_good ? 1'b0 :
                         (r_broken | (w_wd_next == WD_MAX) | (w_bad_next == BAD_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sv_prev <= 1'b0;
      r_wd      <= '0;
      r_bad     <= '0;
      r_broken  <= 1'b0;
    end else begin
      r_sv_prev <= sample_valid;
      r_wd      <= w_wd_next;
      r_bad     <= w_bad_next;
      r_broken  <= w_broken_next;
    end
  end

  // ---- stage p0: capture accepted in-range sample (edge E) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_p0 <= '0;
      r_vld_p0  <= 1'b0;
    end else begin
      r_vld_p0 <= w_acc_good;
      if (w_acc_good) begin
        r_data_p0 <= sample_data;
      end
    end
  end

  // Entries beyond the fill level are always zero (reset/flush clear them),
  // so subtracting the oldest slot is correct even while filling.
  assign w_sum_next = r_sum_p1 + SUM_W'(r_data_p0) - SUM_W'(r_win_p1[3]);

  // ---- stage p1: window shift and running sum (edge E+1) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_win_p1[i] <= '0;
      end
      r_sum_p1  <= '0;
      r_fill_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (r_broken) begin
      for (int i = 0; i < 4; i++) begin
        r_win_p1[i] <= '0;
      end
      r_sum_p1  <= '0;
      r_fill_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (r_vld_p0) begin
      r_win_p1[0] <= r_data_p0;
      r_win_p1[1] <= r_win_p1[0];
      r_win_p1[2] <= r_win_p1[1];
      r_win_p1[3] <= r_win_p1[2];
      r_sum_p1    <= w_sum_next;
      r_fill_p1   <= (r_fill_p1 == FILL_FULL) ? FILL_FULL : r_fill_p1 + 3'd1;
      r_vld_p1    <= (r_fill_p1 >= 3'd3);
    end else begin
      r_vld_p1 <= 1'b0;
    end
  end

  // ---- stage p2: publish average (edge E+2) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt_data_p2 <= '0;
      r_vld_p2       <= 1'b0;
      r_sticky       <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1 & ~r_broken;
      if (r_vld_p1 && !r_broken) begin
        r_filt_data_p2 <= trunc_avg4(r_sum_p1);
        r_sticky       <= 1'b1;
      end
    end
  end

  // ---- occupancy FSM: steps on each published average ----
  assign w_near    = (r_filt_data_p2 < CAR_NEAR);
  assign w_far     = (r_filt_data_p2 > CAR_FAR);
  assign w_cnt_inc = r_cnt + 4'd1;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (r_vld_p2 && !r_broken) begin
      case (r_state)
        S_EMPTY: begin
          if (w_near) begin
            if (CONF == 4'd1) begin
              w_state_next = S_OCCUPIED;
              w_cnt_next   = 4'd0;
            end else begin
              w_state_next = S_ARRIVING;
              w_cnt_next   = 4'd1;
            end
          end
        end
        S_ARRIVING: begin
          if (w_near) begin
            if (w_cnt_inc == CONF) begin
              w_state_next = S_OCCUPIED;
              w_cnt_next   = 4'd0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end else begin
            w_state_next = S_EMPTY;
            w_cnt_next   = 4'd0;
          end
        end
        S_OCCUPIED: begin
          if (w_far) begin
            if (CONF == 4'd1) begin
              w_state_next = S_EMPTY;
              w_cnt_next   = 4'd0;
            end else begin
              w_state_next = S_LEAVING;
              w_cnt_next   = 4'd1;
            end
          end
        end
        default: begin
          if (w_far) begin
            if (w_cnt_inc == CONF) begin
              w_state_next = S_EMPTY;
              w_cnt_next   = 4'd0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end else begin
            w_state_next = S_OCCUPIED;
            w_cnt_next   = 4'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_cnt   <= 4'd0;
      r_car   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_car   <= (w_state_next == S_OCCUPIED) || (w_state_next == S_LEAVING);
    end
  end

  assign filt_data   = r_filt_data_p2;
  assign filt_valid  = r_vld_p2;
  assign car_present = r_car;
  assign broken      = r_broken;
  assign status      = {12'b0, (r_fill_p1 == FILL_FULL), r_broken, r_car, r_sticky};

endmodule
